// File: rtl/serial_link_pkg.sv
// serial_link_pkg: constants and state type shared by the serializer and deserializer
package serial_link_pkg;
    localparam logic [7:0] COMMA_BYTE = 8'hBC;
    localparam int SYNC_COMMAS = 4;
    localparam int BITS_PER_BYTE = 8;
    typedef enum logic {SYNC, RUN} tx_state_t;
endpackage

// File: rtl/paralelo_serial_if.sv
// paralelo_serial_if: byte handshake in, serial stream and status out
// data_count exists only when PS_TX_CNT_EN is defined
interface paralelo_serial_if #(parameter int CNT_W = 16);
    logic [7:0] data_in;
    logic valid_in;
    logic ready_out;
    logic data_out;
    logic active;
`ifdef PS_TX_CNT_EN
    logic [CNT_W-1:0] data_count;
    modport master (output data_in, valid_in, input ready_out, data_out, active, data_count);
    modport slave (input data_in, valid_in, output ready_out, data_out, active, data_count);
`else
    modport master (output data_in, valid_in, input ready_out, data_out, active);
    modport slave (input data_in, valid_in, output ready_out, data_out, active);
`endif
endinterface

// File: rtl/piso_shift8.sv
// piso_shift8: 8-bit load/shift register, MSB first, with a free-running 0..7 bit counter
module piso_shift8
    import serial_link_pkg::*;
(
    input  logic clk_32f,
    input  logic reset,
    input  logic [BITS_PER_BYTE-1:0] load_byte,
    output logic serial,
    output logic load
);
    localparam int BW = $clog2(BITS_PER_BYTE);
    logic [BITS_PER_BYTE-1:0] sreg;
    logic [BW-1:0] bit_cnt;
    always_ff @(posedge clk_32f)
        if (!reset) begin
            sreg <= '0;
            bit_cnt <= BW'(BITS_PER_BYTE - 1);
        end else if (load) begin
            sreg <= load_byte;
            bit_cnt <= '0;
        end else begin
            sreg <= sreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
        end
    assign serial = sreg[BITS_PER_BYTE-1];
    assign load = bit_cnt == BW'(BITS_PER_BYTE - 1);
endmodule

// File: rtl/paralelo_serial.sv
// paralelo_serial: comma-sync preamble, then one data or idle byte per 8-cycle slot
// PS_TX_CNT_EN adds a saturating data_count of transmitted data bytes
module paralelo_serial
    import serial_link_pkg::*;
#(
    parameter logic [7:0] COMMA = COMMA_BYTE,
    parameter int COMMA_COUNT = SYNC_COMMAS,
    parameter int CNT_W = 16
) (
    input logic clk_32f,
    input logic reset,
    paralelo_serial_if.slave bus
);
    localparam int SW = $clog2(COMMA_COUNT) + 1;
    tx_state_t state, state_n;
    logic [SW-1:0] sync_cnt, sync_n;
    logic [7:0] next_byte;
    logic load;
    piso_shift8 u_shift (
        .clk_32f(clk_32f),
        .reset(reset),
        .load_byte(next_byte),
        .serial(bus.data_out),
        .load(load)
    );
    always_ff @(posedge clk_32f)
        if (!reset) begin
            state <= SYNC;
            sync_cnt <= '0;
        end else begin
            state <= state_n;
            sync_cnt <= sync_n;
        end
    always_comb begin
        state_n = state;
        sync_n = sync_cnt;
        next_byte = COMMA;
        if (load && state == SYNC) begin
            sync_n = sync_cnt + 1'b1;
            state_n = sync_cnt == SW'(COMMA_COUNT - 1) ? RUN : SYNC;
        end else if (load && bus.valid_in)
            next_byte = bus.data_in;
    end
    // Both terms are flops, so ready_out has no path from the inputs
    assign bus.ready_out = state == RUN && load;
    assign bus.active = state == RUN;
`ifdef PS_TX_CNT_EN
    logic [CNT_W-1:0] data_count;
    always_ff @(posedge clk_32f)
        if (!reset)
            data_count <= '0;
        else if (bus.valid_in && bus.ready_out && !(&data_count))
            data_count <= data_count + 1'b1;
    assign bus.data_count = data_count;
`endif
endmodule

// File: tb/tb_paralelo_serial.sv
// tb_paralelo_serial: directed checks of sync preamble, handshake, back-to-back data and mid-byte reset
module tb_paralelo_serial;
    logic clk_32f = 0;
    logic reset = 0;
    int total = 0;
    int bad = 0;
    logic [7:0] b;
    paralelo_serial_if #(.CNT_W(16)) bus ();
    paralelo_serial dut (.clk_32f(clk_32f), .reset(reset), .bus(bus.slave));
    always #5 clk_32f = ~clk_32f;

    task automatic tick();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called in the cycle before a load edge; returns the byte shifted out in the slot that follows
    task automatic send_slot(input logic v, input logic [7:0] d, input logic [7:0] junk, output logic [7:0] q);
        bus.valid_in = v;
        bus.data_in = d;
        tick();
        q[7] = bus.data_out;
        bus.data_in = junk;
        for (int i = 6; i >= 0; i--) begin
            tick();
            q[i] = bus.data_out;
        end
    endtask

    task automatic check_count(input string tag, input int exp);
`ifdef PS_TX_CNT_EN
        check(tag, 32'(bus.data_count), 32'(exp));
`endif
    endtask

    initial begin
        bus.valid_in = 0;
        bus.data_in = 8'h00;
        repeat (3) tick();
        check("rst_data_out", bus.data_out, 0);
        check("rst_ready", bus.ready_out, 0);
        check("rst_active", bus.active, 0);
        check_count("rst_count", 0);
        reset = 1;
        for (int k = 0; k < 3; k++) begin
            send_slot(0, 8'h00, 8'h00, b);
            check("sync_comma", b, 8'hBC);
            check("sync_inactive", bus.active, 0);
            check("sync_no_ready", bus.ready_out, 0);
        end
        bus.valid_in = 1;
        bus.data_in = 8'h55;
        tick();
        check("active_at_e25", bus.active, 1);
        check("no_ready_mid_byte", bus.ready_out, 0);
        repeat (7) tick();
        check("first_ready", bus.ready_out, 1);
        send_slot(0, 8'h00, 8'h00, b);
        check("idle_comma", b, 8'hBC);
        check("ready_pulse", bus.ready_out, 1);
        check_count("idle_no_count", 0);
        send_slot(1, 8'hA5, 8'hA5, b);
        check("data_a5", b, 8'hA5);
        send_slot(0, 8'h00, 8'h00, b);
        check("after_a5_idle", b, 8'hBC);
        check_count("count_1", 1);
        send_slot(1, 8'h01, 8'hFF, b);
        check("b2b_01", b, 8'h01);
        send_slot(1, 8'h80, 8'h00, b);
        check("b2b_80", b, 8'h80);
        check_count("count_3", 3);
        bus.valid_in = 1;
        bus.data_in = 8'hC3;
        tick();
        bus.valid_in = 0;
        repeat (3) tick();
        check("bit3_value", bus.data_out, 0);
        reset = 0;
        tick();
        check("mid_rst_data_out", bus.data_out, 0);
        check("mid_rst_active", bus.active, 0);
        check("mid_rst_ready", bus.ready_out, 0);
        check_count("mid_rst_count", 0);
        reset = 1;
        for (int k = 0; k < 4; k++) begin
            send_slot(0, 8'h00, 8'h00, b);
            check("resync_comma", b, 8'hBC);
        end
        check("resync_active", bus.active, 1);
        send_slot(0, 8'hC3, 8'hC3, b);
        check("dropped_not_sent", b, 8'hBC);
        send_slot(1, 8'h3C, 8'h3C, b);
        check("seq_3c", b, 8'h3C);
        send_slot(1, 8'h7E, 8'h7E, b);
        check("seq_7e", b, 8'h7E);
        send_slot(1, 8'hFF, 8'hFF, b);
        check("seq_ff", b, 8'hFF);
        send_slot(0, 8'h00, 8'h00, b);
        check("seq_idle", b, 8'hBC);
        check_count("seq_count", 3);
        send_slot(1, 8'hBC, 8'hBC, b);
        check("comma_as_data", b, 8'hBC);
        check_count("comma_data_counts", 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
